// File: rtl/aes_pkg.sv
// aes_pkg: AES-128 constant, inverse S-box, GF(2^8) helpers and the shared FSM state enum
package aes_pkg;
  localparam int AES_NR = 10;
  typedef enum logic [1:0] {IDLE, ROUND, DONE} aes_state_e;
  localparam logic [0:255][7:0] INV_SBOX_TBL = {
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TBL[b];
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      p = k[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction
  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [3:0] co [4];
    co = '{4'he, 4'hb, 4'hd, 4'h9};
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        for (int j = 0; j < 4; j++)
          o[127-8*(4*c+r) -: 8] ^= gf_mul(s[127-8*(4*c+j) -: 8], co[(j-r+4)%4]);
    return o;
  endfunction
endpackage

// File: rtl/aes_inv_cipher_iter_if.sv
// aes_inv_cipher_iter_if: ciphertext-in and plaintext-out valid/ready handshakes; slave = cipher core, master = its user
interface aes_inv_cipher_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational inverse round; i_state/i_round_key in, o_state out, i_final skips InvMixColumns
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_round_key,
  input  logic         i_final,
  output logic [127:0] o_state
);
  logic [127:0] w_sr, w_sb, w_ark;
  assign w_sr = inv_shift_rows(i_state);
  for (genvar i = 0; i < 16; i++) begin : g_sb
    assign w_sb[8*i +: 8] = inv_sbox(w_sr[8*i +: 8]);
  end
  assign w_ark = w_sb ^ i_round_key;
  assign o_state = i_final ? w_ark : inv_mix_columns(w_ark);
endmodule

// File: rtl/aes_inv_cipher_iter.sv
// aes_inv_cipher_iter: iterative AES-128 decryptor; io_bus carries ciphertext in / plaintext out, o_rk_idx/i_rk_data fetch round keys
module aes_inv_cipher_iter
  import aes_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  aes_inv_cipher_iter_if.slave        io_bus,
  output logic [3:0]                  o_rk_idx,
  input  logic [127:0]                i_rk_data
);
  aes_state_e   r_state, w_next;
  logic [127:0] r_st, w_round;
  logic [3:0]   r_rnd;
  aes_inv_round u_round (
    .i_state     (r_st),
    .i_round_key (i_rk_data),
    .i_final     (r_rnd == 4'd0),
    .o_state     (w_round)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE && io_bus.in_valid) ? ROUND :
             (r_state == ROUND && r_rnd == 4'd0) ? DONE :
             (r_state == DONE && io_bus.out_ready) ? IDLE : r_state;
    io_bus.in_ready = r_state == IDLE;
    io_bus.out_valid = r_state == DONE;
    io_bus.out_data = r_st;
    o_rk_idx = r_state == ROUND ? r_rnd : 4'(AES_NR);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_st <= '0;
      r_rnd <= '0;
    end else if (r_state == IDLE && io_bus.in_valid) begin
      r_st <= io_bus.in_data ^ i_rk_data;
      r_rnd <= 4'(AES_NR - 1);
    end else if (r_state == ROUND) begin
      r_st <= w_round;
      r_rnd <= r_rnd == 4'd0 ? 4'd0 : r_rnd - 4'd1;
    end
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// tb_aes_inv_cipher_iter: directed FIPS-197 vectors plus handshake corner cases for aes_inv_cipher_iter
module tb_aes_inv_cipher_iter;
  typedef struct {
    logic         k;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] rk_idx;
  logic [127:0] rk_data;
  logic ksel, ksel_act, ksel_use;
  logic [127:0] k_c1 [11];
  logic [127:0] k_b [11];
  int n_chk = 0, n_fail = 0, cyc = 0;
  int acc_q[$];
  logic [127:0] out_q[$];
  vec_t vt[3];
  aes_inv_cipher_iter_if bus();
  aes_inv_cipher_iter dut (.clk(clk), .rst(rst), .io_bus(bus), .o_rk_idx(rk_idx), .i_rk_data(rk_data));
  always #5 clk = ~clk;
  // key store: the key set for the next block is chosen while idle and latched on accept
  assign ksel_use = bus.in_ready ? ksel : ksel_act;
  always_comb rk_data = (rk_idx > 4'd10) ? '0 : (ksel_use ? k_b[rk_idx] : k_c1[rk_idx]);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.in_valid && bus.in_ready) begin
      ksel_act <= ksel;
      acc_q.push_back(cyc);
    end
    if (bus.out_valid && bus.out_ready) out_q.push_back(bus.out_data);
  end
  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic do_block(input logic k, input logic [127:0] ct, input int glitch,
                          output int lat, output logic [127:0] pt, output logic [43:0] tr);
    int w;
    @(negedge clk);
    w = 0;
    while (!bus.in_ready && w < 30) begin
      @(negedge clk);
      w++;
    end
    ksel = k;
    bus.in_data = ct;
    bus.in_valid = 1'b1;
    tr = '0;
    tr = {tr[39:0], rk_idx};
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    tr = {tr[39:0], rk_idx};
    lat = 0;
    while (!bus.out_valid && lat < 30) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      bus.in_valid = (lat == glitch);
      if (lat == glitch) bus.in_data = '1;
      if (lat <= 9) tr = {tr[39:0], rk_idx};
    end
    bus.in_valid = 1'b0;
    pt = bus.out_data;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat, w;
    logic [127:0] pt;
    logic [43:0] tr;
    k_c1 = '{128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
             128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
             128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
             128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
             128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
             128'h13111d7fe3944a17f307a78b4d2b30c5};
    k_b  = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
             128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
             128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
             128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
             128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
             128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vt[0] = '{1'b0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff};
    vt[1] = '{1'b1, 128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734};
    vt[2] = vt[0];
    rst = 1'b1;
    ksel = 1'b0;
    ksel_act = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_rk_idx", rk_idx, 10);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      do_block(vt[i].k, vt[i].ct, 0, lat, pt, tr);
      check($sformatf("vec%0d_latency", i), lat, 10);
      check($sformatf("vec%0d_plaintext", i), pt, vt[i].pt);
      if (vt[i].k) check("rk_idx_sequence", tr, 44'ha9876543210);
      @(negedge clk);
      check($sformatf("vec%0d_ready_after", i), bus.in_ready, 1);
      check($sformatf("vec%0d_valid_after", i), bus.out_valid, 0);
    end
    bus.out_ready = 1'b0;
    do_block(vt[0].k, vt[0].ct, 0, lat, pt, tr);
    check("bp_latency", lat, 10);
    check("bp_plaintext", pt, vt[0].pt);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_data_stable", bus.out_data, vt[0].pt);
      check("bp_valid_held", bus.out_valid, 1);
      check("bp_ready_low", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", bus.in_ready, 1);
    check("bp_release_valid", bus.out_valid, 0);
    do_block(vt[1].k, vt[1].ct, 3, lat, pt, tr);
    check("busy_latency", lat, 10);
    check("busy_plaintext", pt, vt[1].pt);
    @(negedge clk);
    ksel = vt[0].k;
    bus.in_data = vt[0].ct;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_busy", bus.in_ready, 0);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_rk_idx", rk_idx, 10);
    @(negedge clk);
    rst = 1'b0;
    do_block(vt[0].k, vt[0].ct, 0, lat, pt, tr);
    check("midrst_latency", lat, 10);
    check("midrst_plaintext", pt, vt[0].pt);
    @(negedge clk);
    acc_q.delete();
    out_q.delete();
    ksel = vt[0].k;
    bus.in_data = vt[0].ct;
    bus.in_valid = 1'b1;
    for (int b = 1; b <= 3; b++) begin
      w = 0;
      while (acc_q.size() < b && w < 40) begin
        @(negedge clk);
        w++;
      end
      if (b < 3) begin
        ksel = vt[b].k;
        bus.in_data = vt[b].ct;
      end else bus.in_valid = 1'b0;
    end
    w = 0;
    while (out_q.size() < 3 && w < 60) begin
      @(negedge clk);
      w++;
    end
    check("b2b_accepts", acc_q.size(), 3);
    check("b2b_outputs", out_q.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("b2b_plaintext%0d", i), (i < out_q.size()) ? out_q[i] : '0, vt[i].pt);
    for (int i = 1; i < 3; i++)
      check($sformatf("b2b_spacing%0d", i), (i < acc_q.size()) ? 128'(acc_q[i] - acc_q[i-1]) : '0, 12);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
